serial_subtractor: RTL and testbench

- Bit-serial N-bit subtractor computing diff = A - B, LSB first, one bit per clock.
- Each bit step uses a full-subtractor cell: d = a ^ b ^ br; br_next = (~a & b) | (~(a ^ b) & br).
- It is the subtract-direction counterpart to the adder datapath. It serves area-constrained ALU paths where the operands arrive and leave over a start/done handshake.

---
 rtl/serial_subtractor.sv | 110 +++++++++++
 tb/tb_serial_subtractor.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = A - B, one full-subtractor step per clock, LSB first.
// Operands are captured on an accepted start; results are registered and pulse done for one cycle.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrowOut,
    output logic             overflow
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res_reg;
    logic [WIDTH-1:0] res_shift;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             a_msb;
    logic             b_msb;

    logic a_bit;
    logic b_bit;
    logic d_bit;
    logic br_next;
    logic last_step;

    always_comb begin
        a_bit     = a_reg[0];
        b_bit     = b_reg[0];
        d_bit     = a_bit ^ b_bit ^ br;
        br_next   = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
        last_step = (cnt == CW'(WIDTH - 1));
    end

    // Difference bits enter at the MSB so the LSB-first result lands in place after WIDTH steps.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_shift = d_bit;
        end else begin : g_res_wn
            assign res_shift = {d_bit, res_reg[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        ready = (state != SHIFT);
        done  = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            cnt       <= '0;
            br        <= 1'b0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            diff      <= '0;
            borrowOut <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_reg   <= A;
                        b_reg   <= B;
                        a_msb   <= A[WIDTH-1];
                        b_msb   <= B[WIDTH-1];
                        res_reg <= '0;
                        br      <= 1'b0;
                        cnt     <= '0;
                        state   <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    a_reg   <= a_reg >> 1;
                    b_reg   <= b_reg >> 1;
                    res_reg <= res_shift;
                    br      <= br_next;
                    cnt     <= cnt + CW'(1);
                    if (last_step) begin
                        // Final bit is folded in here so the results appear together with done.
                        diff      <= res_shift;
                        borrowOut <= br_next;
                        overflow  <= (a_msb != b_msb) && (d_bit != a_msb);
                        state     <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: an 8-bit instance plus a 1-bit instance.
module tb_serial_subtractor;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       ready;
    logic       done;
    logic [7:0] diff;
    logic       bo;
    logic       ov;

    logic reset1;
    logic start1;
    logic a1;
    logic b1;
    logic ready1;
    logic done1;
    logic diff1;
    logic bo1;
    logic ov1;

    int total;
    int bad;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .A         (a),
        .B         (b),
        .ready     (ready),
        .done      (done),
        .diff      (diff),
        .borrowOut (bo),
        .overflow  (ov)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .reset     (reset1),
        .start     (start1),
        .A         (a1),
        .B         (b1),
        .ready     (ready1),
        .done      (done1),
        .diff      (diff1),
        .borrowOut (bo1),
        .overflow  (ov1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // n counts edges from the accepting edge (1) to the edge after which done is seen.
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, output int n);
        a = av;
        b = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
        a = 8'hC3;
        b = 8'h3C;
        n = 1;
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic run_op1(input logic av, input logic bv, output int n);
        a1 = av;
        b1 = bv;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        n = 1;
        while (done1 !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        reset1 = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        reset1 = 1'b0;
        total++;
        if ({ready, done} !== 2'b10) begin
            bad++;
            $display("FAIL reset_ready_done: got %b required 10", {ready, done});
        end
        total++;
        if ({diff, bo, ov} !== 10'h000) begin
            bad++;
            $display("FAIL reset_results: got diff=%h bo=%b ov=%b required 00 0 0", diff, bo, ov);
        end
        total++;
        if ({ready1, done1, diff1, bo1, ov1} !== 5'b10000) begin
            bad++;
            $display("FAIL reset_w1: got %b required 10000", {ready1, done1, diff1, bo1, ov1});
        end
    endtask

    task automatic test_basic();
        int n;
        run_op(8'h05, 8'h03, n);
        total++;
        if (n !== 9) begin
            bad++;
            $display("FAIL basic_latency: got %0d required 9", n);
        end
        total++;
        if ({diff, bo, ov, ready} !== {8'h02, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL basic_result: got diff=%h bo=%b ov=%b ready=%b required 02 0 0 1",
                     diff, bo, ov, ready);
        end
        tick();
        total++;
        if (done !== 1'b0 || diff !== 8'h02) begin
            bad++;
            $display("FAIL basic_pulse: got done=%b diff=%h required 0 02", done, diff);
        end
    endtask

    task automatic test_borrow();
        int n;
        run_op(8'h03, 8'h05, n);
        total++;
        if ({diff, bo, ov} !== {8'hFE, 1'b1, 1'b0} || n !== 9) begin
            bad++;
            $display("FAIL borrow: got diff=%h bo=%b ov=%b n=%0d required FE 1 0 9", diff, bo, ov, n);
        end
        tick();
    endtask

    task automatic test_overflow();
        int n;
        run_op(8'h80, 8'h01, n);
        total++;
        if ({diff, bo, ov} !== {8'h7F, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL ovf_80_01: got diff=%h bo=%b ov=%b required 7F 0 1", diff, bo, ov);
        end
        tick();
        run_op(8'h7F, 8'hFF, n);
        total++;
        if ({diff, bo, ov} !== {8'h80, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL ovf_7f_ff: got diff=%h bo=%b ov=%b required 80 1 1", diff, bo, ov);
        end
        tick();
    endtask

    task automatic test_busy();
        int n;
        int extra;
        a = 8'h05;
        b = 8'h03;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        total++;
        if (ready !== 1'b0) begin
            bad++;
            $display("FAIL busy_ready: got %b required 0", ready);
        end
        a = 8'hAA;
        b = 8'h55;
        start = 1'b1;
        tick();
        start = 1'b0;
        a = 8'h00;
        b = 8'h00;
        n = 4;
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (n !== 9 || diff !== 8'h02) begin
            bad++;
            $display("FAIL busy_ignored: got n=%0d diff=%h required 9 02", n, diff);
        end
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1) extra++;
        end
        total++;
        if (extra !== 0) begin
            bad++;
            $display("FAIL busy_no_queue: got %0d extra done pulses required 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        int hits;
        int next_at;
        a = 8'h10;
        b = 8'h01;
        start = 1'b1;
        tick();
        hits = 0;
        next_at = 9;
        for (int i = 2; i <= 27; i++) begin
            tick();
            if (done === 1'b1) begin
                hits++;
                total++;
                if (i !== next_at || diff !== 8'h0F) begin
                    bad++;
                    $display("FAIL b2b_pulse: got edge=%0d diff=%h required edge=%0d diff=0F",
                             i, diff, next_at);
                end
                next_at = next_at + 9;
            end
        end
        start = 1'b0;
        total++;
        if (hits !== 3) begin
            bad++;
            $display("FAIL b2b_count: got %0d required 3", hits);
        end
        tick();
        total++;
        if ({ready, done} !== 2'b10) begin
            bad++;
            $display("FAIL b2b_idle: got ready/done=%b required 10", {ready, done});
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int seen;
        run_op(8'h7F, 8'hFF, n);
        tick();
        a = 8'h55;
        b = 8'hAA;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if ({ready, done, diff, bo, ov} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL midreset_state: got ready=%b done=%b diff=%h bo=%b ov=%b required 1 0 00 0 0",
                     ready, done, diff, bo, ov);
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL midreset_no_done: got %0d pulses required 0", seen);
        end
        run_op(8'h00, 8'h00, n);
        total++;
        if (n !== 9 || {diff, bo, ov} !== 10'h000) begin
            bad++;
            $display("FAIL midreset_zero: got n=%0d diff=%h bo=%b ov=%b required 9 00 0 0",
                     n, diff, bo, ov);
        end
        tick();
    endtask

    task automatic test_width1();
        int n;
        run_op1(1'b0, 1'b1, n);
        total++;
        // 0 - (-1) = +1 does not fit 1-bit signed, so overflow is set.
        if (n !== 2 || {diff1, bo1, ov1} !== 3'b111) begin
            bad++;
            $display("FAIL w1_0_1: got n=%0d diff=%b bo=%b ov=%b required 2 1 1 1", n, diff1, bo1, ov1);
        end
        tick();
        total++;
        if (done1 !== 1'b0 || ready1 !== 1'b1) begin
            bad++;
            $display("FAIL w1_pulse: got done=%b ready=%b required 0 1", done1, ready1);
        end
        run_op1(1'b1, 1'b0, n);
        total++;
        if (n !== 2 || {diff1, bo1, ov1} !== 3'b100) begin
            bad++;
            $display("FAIL w1_1_0: got n=%0d diff=%b bo=%b ov=%b required 2 1 0 0", n, diff1, bo1, ov1);
        end
        tick();
        run_op1(1'b1, 1'b1, n);
        total++;
        if (n !== 2 || {diff1, bo1, ov1} !== 3'b000) begin
            bad++;
            $display("FAIL w1_1_1: got n=%0d diff=%b bo=%b ov=%b required 2 0 0 0", n, diff1, bo1, ov1);
        end
        tick();
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b0;
        start = 1'b0;
        a = 8'h00;
        b = 8'h00;
        reset1 = 1'b0;
        start1 = 1'b0;
        a1 = 1'b0;
        b1 = 1'b0;
        #2;
        test_reset();
        test_basic();
        test_borrow();
        test_overflow();
        test_busy();
        test_back_to_back();
        test_reset_mid();
        test_width1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
